// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - shared state and result encodings for the run sequencer
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TIMEOUT = 2'd1,
    FC_ABORT   = 2'd2
  } fail_code_e;

endpackage

// File: rtl/run_seq_ctrl.sv
// rtl/run_seq_ctrl.sv - test-run sequencer: DUT reset hold, run counting, pass/fail report
module run_seq_ctrl
  import run_seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             dut_done,
  output logic             dut_reset_l,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  fail_code_e         fail_code_q, fail_code_d;
  logic               dut_reset_l_q, dut_reset_l_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    limit_d       = limit_q;
    cycle_count_d = cycle_count_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    fail_code_d   = fail_code_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = HOLD;
          limit_d       = cfg_limit;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          fail_code_d   = FC_NONE;
          cycle_count_d = '0;
          hold_cnt_d    = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (abort) begin
          state_d     = REPORT;
          fail_d      = 1'b1;
          fail_code_d = FC_ABORT;
        end else if (hold_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      RUN: begin
        // Counter advances even on the exit cycle, so a timeout reports exactly the limit.
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (abort) begin
          state_d     = REPORT;
          fail_d      = 1'b1;
          fail_code_d = FC_ABORT;
        end else if (dut_done) begin
          state_d = REPORT;
          pass_d  = 1'b1;
        end else if ((limit_q != '0) && (cycle_count_q == limit_q - CNT_W'(1))) begin
          state_d     = REPORT;
          fail_d      = 1'b1;
          fail_code_d = FC_TIMEOUT;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dut_reset_l_d = (state_d == RUN);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == REPORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      limit_q       <= '0;
      cycle_count_q <= '0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_code_q   <= FC_NONE;
      dut_reset_l_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      limit_q       <= limit_d;
      cycle_count_q <= cycle_count_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      fail_code_q   <= fail_code_d;
      dut_reset_l_q <= dut_reset_l_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign dut_reset_l = dut_reset_l_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_seq_ctrl.sv
// tb/tb_run_seq_ctrl.sv - self-checking bench for run_seq_ctrl against a run-outcome model
module tb_run_seq_ctrl;

  localparam int CNT_W   = 8;
  localparam int HOLD    = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int NEVER   = -1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             dut_done = 1'b0;
  logic             dut_reset_l, busy, done, pass, fail;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] cycle_count;

  int n_total = 0;
  int n_pass  = 0;

  run_seq_ctrl #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_limit(cfg_limit), .dut_done(dut_done),
    .dut_reset_l(dut_reset_l), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle_reset_values(input string tag);
    chk({tag, ".dut_reset_l"}, 32'(dut_reset_l), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".fail"}, 32'(fail), 0);
    chk({tag, ".fail_code"}, 32'(fail_code), 0);
    chk({tag, ".cycle_count"}, 32'(cycle_count), 0);
  endtask

  // Outcome of one run derived from the exit rules; timeline counts cycles from start acceptance (t=0).
  // Periods 1..HOLD are HOLD, RUN starts at HOLD+1, REPORT is period rpt.
  task automatic do_run(input string tag, input int limit, input int abort_t,
                        input int done_r, input bit noise);
    int  rpt, exp_cnt, exp_code, r, ra, rd, rl;
    bit  exp_pass, hold_abort, in_run;
    hold_abort = (abort_t >= 1) && (abort_t <= HOLD);
    if (hold_abort) begin
      rpt = abort_t + 1; exp_cnt = 0; exp_code = 2; exp_pass = 0;
    end else begin
      ra = (abort_t > HOLD) ? abort_t - (HOLD + 1) : 1 << 30;
      rd = (done_r >= 0) ? done_r : 1 << 30;
      rl = (limit != 0) ? limit - 1 : 1 << 30;
      r = ra;
      if (rd < r) r = rd;
      if (rl < r) r = rl;
      if (r == ra)      begin exp_code = 2; exp_pass = 0; end
      else if (r == rd) begin exp_code = 0; exp_pass = 1; end
      else              begin exp_code = 1; exp_pass = 0; end
      exp_cnt = (r + 1 > SAT) ? SAT : r + 1;
      rpt = HOLD + 1 + r + 1;
    end

    for (int t = 0; t <= rpt; t++) begin
      in_run    = !hold_abort && (t >= HOLD + 1) && (t < rpt);
      start     = (t == 0) || (noise && t > 0 && $urandom_range(0, 3) == 0);
      cfg_limit = (t == 0) ? CNT_W'(limit) : CNT_W'($urandom);
      abort     = (t == abort_t);
      dut_done  = in_run ? (t - (HOLD + 1) == done_r) : (noise && $urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      chk({tag, ".busy"}, 32'(busy), 32'((t + 1 >= 1) && (t + 1 <= rpt)));
      chk({tag, ".dut_reset_l"}, 32'(dut_reset_l),
          32'(!hold_abort && (t + 1 >= HOLD + 1) && (t + 1 < rpt)));
      chk({tag, ".done"}, 32'(done), 32'(t + 1 == rpt));
      chk({tag, ".pass_and_fail"}, 32'(pass & fail), 0);
    end
    start = 1'b0; abort = 1'b0; dut_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
      chk({tag, ".fail"}, 32'(fail), 32'(!exp_pass));
      chk({tag, ".fail_code"}, 32'(fail_code), 32'(exp_code));
      chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(exp_cnt));
      abort    = noise && ($urandom_range(0, 1) == 1);
      dut_done = noise && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    abort = 1'b0; dut_done = 1'b0;
  endtask

  initial begin
    int lim, ab, dn;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_idle_reset_values("idle_after_reset");

    do_run("timeout30", 30, NEVER, NEVER, 1'b0);
    do_run("done_at10", 100, NEVER, 10, 1'b0);
    do_run("done_vs_timeout", 5, NEVER, 4, 1'b0);
    do_run("abort_hold2", 20, 2, NEVER, 1'b1);
    do_run("start_abort_idle", 10, 0, NEVER, 1'b0);
    do_run("abort_vs_done", 40, HOLD + 1 + 6, 6, 1'b1);
    do_run("nolimit_done50", 0, NEVER, 50, 1'b0);
    do_run("saturate", 0, NEVER, 300, 1'b1);
    do_run("limit1", 1, NEVER, NEVER, 1'b1);

    // Reset mid-run: a second start in RUN must not restart, and reset gives no done pulse.
    start = 1'b1; cfg_limit = '0;
    for (int t = 0; t < HOLD + 1 + 7; t++) begin
      @(posedge clk); #1;
      start = (t == HOLD + 3);
      cfg_limit = CNT_W'(3);
    end
    chk("midrun.cycle_count", 32'(cycle_count), 7);
    chk("midrun.dut_reset_l", 32'(dut_reset_l), 1);
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle_reset_values("midrun_reset");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrun.no_done", 32'(done), 0);
      chk("midrun.stays_idle", 32'(busy), 0);
    end

    for (int i = 0; i < 25; i++) begin
      lim = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 60));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : NEVER;
      dn  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 70)) : NEVER;
      if (lim == 0 && dn < 0 && ab <= HOLD) dn = int'($urandom_range(0, 40));
      do_run($sformatf("rand%0d", i), lim, ab, dn, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/run_seq_ctrl.md
Name: run_seq_ctrl

Overview:
- Test-run sequencer that owns the DUT-side counter/run lifecycle.
- On `start`, it holds the downstream block in reset for a fixed number of cycles, then releases it and counts run cycles.
- It ends the run on a DUT completion flag, a programmable cycle limit (timeout), or an abort, and reports pass/fail.
- Sits between the bench top and the counting sub-block, replacing hard-coded finish thresholds with a configurable, checkable controller.

Parameters:
- CNT_W, 32, width of the cycle counter and limit.
- HOLD_CYCLES, 4, cycles the DUT reset is held low after `start`; must be >= 1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- abort  in  1  terminate the current run.
- cfg_limit  in  CNT_W  run-cycle limit, sampled at `start` acceptance; 0 = no limit.
- dut_done  in  1  DUT completion indication; sampled only in RUN.
- dut_reset_l  out  1  active-low reset to the DUT.
- busy  out  1  high in HOLD, RUN and REPORT.
- done  out  1  one-cycle pulse in REPORT.
- pass  out  1  sticky result: run completed by `dut_done`.
- fail  out  1  sticky result: timeout or abort.
- fail_code  out  2  0 = none, 1 = timeout, 2 = abort; 3 is unused.
- cycle_count  out  CNT_W  RUN cycles elapsed; holds its value after the run.

Behaviour:
- Reset values:
  - state = IDLE
  - dut_reset_l = 0, busy = 0, done = 0
  - pass = 0, fail = 0, fail_code = 0
  - cycle_count = 0, hold counter = 0, latched limit = 0
- IDLE:
  - dut_reset_l = 0.
  - `start` = 1 → next cycle HOLD; latch `cfg_limit`; clear pass, fail, fail_code and cycle_count; load hold counter with HOLD_CYCLES-1.
  - `abort` in IDLE is ignored.
- HOLD:
  - dut_reset_l = 0.
  - Hold counter decrements each cycle; when it is 0 → RUN. HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - `abort` → REPORT with fail = 1, fail_code = 2.
- RUN:
  - dut_reset_l = 1.
  - cycle_count increments by 1 each RUN cycle and does not wrap: it saturates at all-ones.
  - Exit priority, highest first:
    1. `abort` → REPORT, fail_code = 2.
    2. `dut_done` → REPORT, pass = 1.
    3. latched limit != 0 and cycle_count == limit-1 → REPORT, fail = 1, fail_code = 1.
  - The increment also occurs on the exit cycle, so a timeout leaves cycle_count == limit.
  - limit == 0: only `dut_done` or `abort` end the run.
- REPORT:
  - Lasts exactly one cycle: done = 1, busy = 1, dut_reset_l = 0.
  - Next state is IDLE. pass, fail, fail_code and cycle_count stay stable until the next accepted `start`.
- Boundary rules:
  - `start` while busy is ignored (no restart, no re-latch).
  - `start` and `abort` together in IDLE → `start` is accepted.
  - `dut_done` outside RUN is ignored.
  - `reset` mid-run → IDLE immediately next cycle with all reset values; no `done` pulse.
- Invariant: pass and fail are never both high.

Decomposition:
- Package run_seq_pkg holds:
  - typedef enum logic [1:0] state_e = {IDLE, HOLD, RUN, REPORT}.
  - typedef enum logic [1:0] fail_code_e = {FC_NONE = 0, FC_TIMEOUT = 1, FC_ABORT = 2}.
- No sub-module: FSM, hold counter and saturating run counter live in one module.

Test Plan:
- Reset, then `start` with cfg_limit = 30 and `dut_done` never asserted → dut_reset_l low for 4 cycles after `start`; `done` pulses; fail = 1, fail_code = 1, cycle_count = 30.
- cfg_limit = 100, `dut_done` pulsed on RUN cycle 10 (cycle_count == 10) → pass = 1, fail = 0, cycle_count = 11; `done` on the following cycle.
- cfg_limit = 5, `dut_done` and the timeout condition on the same cycle (cycle_count == 4) → pass = 1, fail_code = 0.
- `abort` during HOLD cycle 2 → REPORT on the next cycle, fail_code = 2, cycle_count = 0, dut_reset_l never went high.
- `start` pulsed again during RUN, then `reset` asserted at cycle_count = 7 → the second `start` has no effect; after reset all outputs are at reset values and no `done` pulse occurs.
- cfg_limit = 0 and `dut_done` at cycle_count == 50 → pass = 1; separately, with force-loaded cycle_count = all-ones, the counter saturates and does not wrap.
